debouncer_multi: RTL and testbench

//  Multi-channel successor to the single-input button debouncer. Per channel: synchroniser,

---
 rtl/debouncer_multi_pkg.sv | 24 ++
 rtl/debouncer_multi_if.sv | 33 +++
 rtl/debouncer_multi_channel.sv | 153 +++++++++++++++
 rtl/debouncer_multi.sv | 49 ++++
 tb/tb_debouncer_multi.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/debouncer_multi_pkg.sv
// Shared types and default timing for the multi-channel button debouncer.
//   rep_state_e     : per-channel auto-repeat FSM encoding
//   Def*            : default widths for a 50 MHz board clock
//   max_bits()      : width helper for the shared hold/repeat counter
package debouncer_multi_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHold   = 2'd1,
    StRepeat = 2'd2
  } rep_state_e;

  // At 50 MHz: 2**19 cycles ~ 10.5 ms settle, 2**26 ~ 1.34 s to first repeat,
  // 2**23 ~ 168 ms between repeats.
  localparam int unsigned DefDebounceBits = 19;
  localparam int unsigned DefSyncStages   = 2;
  localparam int unsigned DefHoldBits     = 26;
  localparam int unsigned DefRepeatBits   = 23;

  function automatic int unsigned max_bits(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debouncer_multi_if.sv
// Button bundle between raw pins and the stopwatch control logic.
//   input_unstable : raw asynchronous levels (1 = pressed)
//   output_stable  : debounced levels
//   rise_o/fall_o  : 1-cycle pulses on debounced 0->1 / 1->0
//   repeat_o       : 1-cycle auto-repeat pulse while held
// master = pin/stimulus side, slave = debouncer side.
interface debouncer_multi_if #(
  parameter int unsigned NUM_CH = 3
) ();

  logic [NUM_CH-1:0] input_unstable;
  logic [NUM_CH-1:0] output_stable;
  logic [NUM_CH-1:0] rise_o;
  logic [NUM_CH-1:0] fall_o;
  logic [NUM_CH-1:0] repeat_o;

  modport master (
    output input_unstable,
    input  output_stable,
    input  rise_o,
    input  fall_o,
    input  repeat_o
  );

  modport slave (
    input  input_unstable,
    output output_stable,
    output rise_o,
    output fall_o,
    output repeat_o
  );

endinterface

// File: rtl/debouncer_multi_channel.sv
// One debounce channel: synchroniser chain, saturating agreement counter,
// registered edge pulses and an optional hold-to-repeat FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw_i      : raw button level
//   stable_o   : debounced level
//   rise_o     : 1-cycle pulse in the first cycle stable_o is 1
//   fall_o     : 1-cycle pulse in the first cycle stable_o is 0
//   repeat_o   : 1-cycle auto-repeat pulse while held (0 when REPEAT_EN = 0)
module debouncer_multi_channel
  import debouncer_multi_pkg::*;
#(
  parameter int unsigned COUNTER_BITS = DefDebounceBits,
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter bit          REPEAT_EN    = 1'b1,
  parameter int unsigned HOLD_BITS    = DefHoldBits,
  parameter int unsigned REPEAT_BITS  = DefRepeatBits
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);

  localparam logic [COUNTER_BITS-1:0] CntMax = '1;
  localparam logic [COUNTER_BITS-1:0] CntOne = COUNTER_BITS'(1);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync;
  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic                    stable_q, stable_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;

  // Synchroniser: only the last stage is seen downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Count consecutive disagreeing cycles; any agreement clears the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync;
        rise_d   = sync;
        fall_d   = ~sync;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

  if (REPEAT_EN) begin : g_repeat
    localparam int unsigned HcntBits = max_bits(HOLD_BITS, REPEAT_BITS);
    localparam logic [HcntBits-1:0] HoldTc = HcntBits'({HOLD_BITS{1'b1}});
    localparam logic [HcntBits-1:0] RepTc  = HcntBits'({REPEAT_BITS{1'b1}});
    localparam logic [HcntBits-1:0] HOne   = HcntBits'(1);

    rep_state_e          state_q, state_d;
    logic [HcntBits-1:0] hcnt_q, hcnt_d;
    logic                rpt_q, rpt_d;

    // The FSM leaves IDLE on the same edge that commits the rise, so hcnt is 0
    // in the rise_o cycle and the registered pulse lands exactly 2**HOLD_BITS later.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      rpt_d   = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise_d) begin
            state_d = StHold;
            hcnt_d  = '0;
          end
        end
        StHold: begin
          if (hcnt_q == HoldTc) begin
            rpt_d   = 1'b1;
            hcnt_d  = '0;
            state_d = StRepeat;
          end else begin
            hcnt_d = hcnt_q + HOne;
          end
        end
        StRepeat: begin
          if (hcnt_q == RepTc) begin
            rpt_d  = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + HOne;
          end
        end
        default: begin
          state_d = StIdle;
          hcnt_d  = '0;
        end
      endcase
      // Release wins over a coincident terminal count.
      if (fall_d || (!stable_q && state_q != StIdle)) begin
        state_d = StIdle;
        hcnt_d  = '0;
        rpt_d   = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        hcnt_q  <= '0;
        rpt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        rpt_q   <= rpt_d;
      end
    end

    assign repeat_o = rpt_q;
  end else begin : g_no_repeat
    assign repeat_o = 1'b0;
  end

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel push-button debouncer for the stopwatch keys.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : debouncer_multi_if slave (raw levels in; stable level,
//                rise/fall pulses and auto-repeat pulses out, one bit per channel)
// Channels are fully independent; this level is wiring only.
module debouncer_multi
  import debouncer_multi_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned COUNTER_BITS = DefDebounceBits,
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter bit          REPEAT_EN    = 1'b1,
  parameter int unsigned HOLD_BITS    = DefHoldBits,
  parameter int unsigned REPEAT_BITS  = DefRepeatBits
) (
  input logic              clk,
  input logic              rst_n,
  debouncer_multi_if.slave btn
);

  logic [NUM_CH-1:0] stable_w;
  logic [NUM_CH-1:0] rise_w;
  logic [NUM_CH-1:0] fall_w;
  logic [NUM_CH-1:0] repeat_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debouncer_multi_channel #(
      .COUNTER_BITS (COUNTER_BITS),
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_EN    (REPEAT_EN),
      .HOLD_BITS    (HOLD_BITS),
      .REPEAT_BITS  (REPEAT_BITS)
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (btn.input_unstable[i]),
      .stable_o (stable_w[i]),
      .rise_o   (rise_w[i]),
      .fall_o   (fall_w[i]),
      .repeat_o (repeat_w[i])
    );
  end

  assign btn.output_stable = stable_w;
  assign btn.rise_o        = rise_w;
  assign btn.fall_o        = fall_w;
  assign btn.repeat_o      = repeat_w;

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi (COUNTER_BITS=4, SYNC_STAGES=2, HOLD_BITS=5,
// REPEAT_BITS=3). Stimulus pushes the expected pulse cycles into a queue; a negedge
// monitor pops one entry whenever any pulse is visible. A second instance built with
// REPEAT_EN=0 shares the inputs and must never pulse repeat_o.
module tb_debouncer_multi;

  localparam int unsigned NCh = 3;

  typedef struct {
    int         at;
    logic [2:0] r;
    logic [2:0] f;
    logic [2:0] p;
    logic [2:0] s;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] in_v = '0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         norep_seen = 1'b0;
  ev_t        exp_q[$];

  debouncer_multi_if #(.NUM_CH(NCh)) bus_a ();
  debouncer_multi_if #(.NUM_CH(NCh)) bus_b ();

  assign bus_a.input_unstable = in_v;
  assign bus_b.input_unstable = in_v;

  debouncer_multi #(
    .NUM_CH       (NCh),
    .COUNTER_BITS (4),
    .SYNC_STAGES  (2),
    .REPEAT_EN    (1'b1),
    .HOLD_BITS    (5),
    .REPEAT_BITS  (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus_a)
  );

  debouncer_multi #(
    .NUM_CH       (NCh),
    .COUNTER_BITS (4),
    .SYNC_STAGES  (2),
    .REPEAT_EN    (1'b0),
    .HOLD_BITS    (5),
    .REPEAT_BITS  (3)
  ) dut_norep (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any visible pulse consumes the next expected event.
  always @(negedge clk) begin : mon
    ev_t e;
    if (bus_b.repeat_o != 3'b000) norep_seen = 1'b1;
    if ((bus_a.rise_o | bus_a.fall_o | bus_a.repeat_o) != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d rise=%b fall=%b rep=%b stable=%b", cyc,
                 bus_a.rise_o, bus_a.fall_o, bus_a.repeat_o, bus_a.output_stable);
      end else begin
        e = exp_q.pop_front();
        if (e.at != cyc || e.r != bus_a.rise_o || e.f != bus_a.fall_o ||
            e.p != bus_a.repeat_o || e.s != bus_a.output_stable) begin
          errors++;
          $display("FAIL event got cyc=%0d rise=%b fall=%b rep=%b stable=%b expected cyc=%0d rise=%b fall=%b rep=%b stable=%b",
                   cyc, bus_a.rise_o, bus_a.fall_o, bus_a.repeat_o, bus_a.output_stable,
                   e.at, e.r, e.f, e.p, e.s);
        end
      end
    end
  end

  task automatic expect_ev(input int at, input logic [2:0] r, input logic [2:0] f,
                           input logic [2:0] p, input logic [2:0] s);
    ev_t e;
    int  i;
    e = '{at: at, r: r, f: f, p: p, s: s};
    i = 0;
    while (i < exp_q.size() && exp_q[i].at <= at) i++;
    exp_q.insert(i, e);
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int r;

    // Reset state.
    #1 rst_n = 1'b0;
    #2;
    check3("rst_stable", bus_a.output_stable, 3'b000);
    check3("rst_rise", bus_a.rise_o, 3'b000);
    check3("rst_fall", bus_a.fall_o, 3'b000);
    check3("rst_repeat", bus_a.repeat_o, 3'b000);
    tick(2);
    rst_n = 1'b1;
    tick(5);

    // 1: bounce on ch0 never settles.
    for (int i = 0; i < 4; i++) begin
      in_v[0] = 1'b1; tick(1);
      in_v[0] = 1'b0; tick(1);
    end
    in_v[0] = 1'b1; tick(3);
    in_v[0] = 1'b0; tick(30);
    check3("bounce_stable", bus_a.output_stable, 3'b000);

    // 2: 15 cycles high is one short; 16 commits after 2 sync + 16 count cycles.
    in_v[0] = 1'b1; tick(15);
    in_v[0] = 1'b0; tick(25);
    check3("hold15_stable", bus_a.output_stable, 3'b000);
    c = cyc;
    in_v[0] = 1'b1;
    expect_ev(c + 18, 3'b001, 3'b000, 3'b000, 3'b001);
    tick(16);
    in_v[0] = 1'b0;
    expect_ev(c + 34, 3'b000, 3'b001, 3'b000, 3'b000);
    tick(40);

    // 3: hold ch1 -> repeats at rise+32, then every 8; clean release.
    c = cyc;
    r = c + 18;
    in_v[1] = 1'b1;
    expect_ev(r, 3'b010, 3'b000, 3'b000, 3'b010);
    for (int k = 32; k <= 64; k += 8) expect_ev(r + k, 3'b000, 3'b000, 3'b010, 3'b010);
    expect_ev(r + 68, 3'b000, 3'b010, 3'b000, 3'b000);
    tick(68);
    in_v[1] = 1'b0;
    tick(80);

    // 4: release commits on the cycle a repeat would otherwise fire (rise+48).
    c = cyc;
    r = c + 18;
    in_v[1] = 1'b1;
    expect_ev(r, 3'b010, 3'b000, 3'b000, 3'b010);
    expect_ev(r + 32, 3'b000, 3'b000, 3'b010, 3'b010);
    expect_ev(r + 40, 3'b000, 3'b000, 3'b010, 3'b010);
    expect_ev(r + 48, 3'b000, 3'b010, 3'b000, 3'b000);
    tick(48);
    in_v[1] = 1'b0;
    tick(60);

    // 5: ch0 and ch2 together while ch1 chatters every cycle.
    c = cyc;
    expect_ev(c + 18, 3'b101, 3'b000, 3'b000, 3'b101);
    expect_ev(c + 38, 3'b000, 3'b101, 3'b000, 3'b000);
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        in_v[0] = 1'b1;
        in_v[2] = 1'b1;
      end
      if (i == 20) begin
        in_v[0] = 1'b0;
        in_v[2] = 1'b0;
      end
      in_v[1] = i[0];
      tick(1);
    end
    in_v[1] = 1'b0;
    tick(30);

    // 6: async reset with ch0 in HOLD and ch2 mid-count; inputs stay high.
    c = cyc;
    in_v[0] = 1'b1;
    expect_ev(c + 18, 3'b001, 3'b000, 3'b000, 3'b001);
    tick(22);
    in_v[2] = 1'b1;
    tick(8);
    check3("pre_rst_stable", bus_a.output_stable, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    check3("async_rst_stable", bus_a.output_stable, 3'b000);
    check3("async_rst_rise", bus_a.rise_o, 3'b000);
    check3("async_rst_fall", bus_a.fall_o, 3'b000);
    check3("async_rst_repeat", bus_a.repeat_o, 3'b000);
    tick(3);
    rst_n = 1'b1;
    c = cyc;
    expect_ev(c + 18, 3'b101, 3'b000, 3'b000, 3'b101);
    tick(20);
    in_v = 3'b000;
    expect_ev(c + 38, 3'b000, 3'b101, 3'b000, 3'b000);
    tick(40);

    // Every expected event must have been seen; the REPEAT_EN=0 build never repeats.
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events pending=%0d expected=0 first_at=%0d", exp_q.size(),
               exp_q[0].at);
    end
    checks++;
    if (norep_seen) begin
      errors++;
      $display("FAIL norep_repeat got=1 expected=0");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
